// File: rtl/apb_timer.sv
// apb_timer: APB slave up-counter timer with prescaler, auto-reload compare and sticky update flag.
// Zero-wait-state bus; irq is the level AND of the update flag and its enable.
module apb_timer #(
   parameter int PSC_WIDTH = 16,
   parameter int CNT_WIDTH = 32
) (
   input  logic        PCLK,
   input  logic        PRESET,
   input  logic [31:0] PADDR,
   input  logic        PWRITE,
   input  logic        PENABLE,
   input  logic [31:0] PWDATA,
   input  logic        PSEL,
   output logic [31:0] PRDATA,
   output logic        PREADY,
   output logic        irq
);
   logic [2:0]           addr;
   logic                 wr, rd, clr, tick, wrap, set, w1c;
   logic                 en, ie, uif;
   logic [PSC_WIDTH-1:0] psc, psc_cnt;
   logic [CNT_WIDTH-1:0] arr, cnt;
   logic                 unused_addr;

   assign addr        = PADDR[4:2];
   assign unused_addr = ^{PADDR[31:5], PADDR[1:0]};
   assign PREADY      = PSEL & PENABLE;
   assign wr          = PREADY & PWRITE;
   assign rd          = PREADY & ~PWRITE;
   assign clr         = wr && addr == 3'd0 && PWDATA[1];
   // '>=' rather than '==' so lowering PSC/ARR below the running count wraps instead of rolling over
   assign tick        = en && psc_cnt >= psc;
   assign wrap        = cnt >= arr;
   assign set         = tick && wrap && !clr;
   assign w1c         = wr && addr == 3'd4 && PWDATA[0];
   assign irq         = uif & ie;

   always_ff @(posedge PCLK or posedge PRESET)
      if (PRESET) begin
         en      <= 1'b0;
         ie      <= 1'b0;
         psc     <= '0;
         arr     <= '0;
         psc_cnt <= '0;
         cnt     <= '0;
         uif     <= 1'b0;
      end else begin
         if (wr && addr == 3'd0) begin
            en <= PWDATA[0];
            ie <= PWDATA[2];
         end
         if (wr && addr == 3'd1) psc <= PWDATA[PSC_WIDTH-1:0];
         if (wr && addr == 3'd2) arr <= PWDATA[CNT_WIDTH-1:0];
         if (clr) begin
            psc_cnt <= '0;
            cnt     <= '0;
         end else if (en) begin
            psc_cnt <= tick ? '0 : psc_cnt + 1'b1;
            if (tick) cnt <= wrap ? '0 : cnt + 1'b1;
         end
         // a hardware set beats a same-edge W1C
         if (set) uif <= 1'b1;
         else if (w1c) uif <= 1'b0;
      end

   always_comb
      PRDATA = !rd           ? 32'd0 :
               addr == 3'd0  ? {29'd0, ie, 1'b0, en} :
               addr == 3'd1  ? 32'(psc) :
               addr == 3'd2  ? 32'(arr) :
               addr == 3'd3  ? 32'(cnt) :
               addr == 3'd4  ? {31'd0, uif} : 32'd0;
endmodule

// File: tb/tb_apb_timer.sv
// tb_apb_timer: scenario tasks for apb_timer with a queue of expected values
// filled as stimulus is issued and drained as the bus returns data.
module tb_apb_timer;
   logic        PCLK = 1'b0, PRESET = 1'b1;
   logic [31:0] PADDR = '0, PWDATA = '0;
   logic        PWRITE = 1'b0, PENABLE = 1'b0, PSEL = 1'b0;
   logic [31:0] PRDATA;
   logic        PREADY, irq;
   int          errors = 0, checks = 0, cyc = 0, cyc_en = 0;
   logic [31:0] exp_q[$];
   logic        irq_q[$];
   logic [31:0] rd, e;
   logic        rdy, ei;

   localparam logic [31:0] A_CR = 32'h00, A_PSC = 32'h04, A_ARR = 32'h08, A_CNT = 32'h0C, A_SR = 32'h10;

   apb_timer dut (
      .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWRITE(PWRITE), .PENABLE(PENABLE),
      .PWDATA(PWDATA), .PSEL(PSEL), .PRDATA(PRDATA), .PREADY(PREADY), .irq(irq)
   );

   always #5 PCLK = ~PCLK;
   always @(posedge PCLK) cyc <= cyc + 1;

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge PCLK);
         #1;
      end
   endtask

   // commit edge is the third edge after the call; returns 1ns after it
   task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
      @(posedge PCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   // data sampled in the access phase, two edges after the call
   task automatic apb_read(input logic [31:0] a, output logic [31:0] d, output logic r);
      @(posedge PCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      #3;
      d = PRDATA;
      r = PREADY;
      @(posedge PCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge PCLK); #2;
      PRESET = 1'b1;
      #2;
      PRESET = 1'b0;
      @(posedge PCLK); #1;
   endtask

   task automatic start(input logic [31:0] p, input logic [31:0] a, input logic [31:0] c);
      apb_write(A_PSC, p);
      apb_write(A_ARR, a);
      apb_write(A_CR, c);
      cyc_en = cyc;
   endtask

   task automatic wait_k(input int k);
      while (cyc - cyc_en < k) begin
         @(posedge PCLK);
         #1;
      end
   endtask

   task automatic test_reset();
      logic [31:0] regs [5];
      regs = '{A_CR, A_PSC, A_ARR, A_CNT, A_SR};
      start(0, 2, 5);
      idle(8);
      irq_q.push_back(1'b1);
      ei = irq_q.pop_front(); checks++;
      if (irq !== ei) begin errors++; $display("FAIL reset_pre_irq: got %b expected %b", irq, ei); end
      @(posedge PCLK); #2;
      PRESET = 1'b1;
      #1;
      irq_q.push_back(1'b0);
      ei = irq_q.pop_front(); checks++;
      if (irq !== ei) begin errors++; $display("FAIL reset_async_irq: got %b expected %b", irq, ei); end
      checks++;
      if (PREADY !== 1'b0) begin errors++; $display("FAIL reset_pready: got %b expected 0", PREADY); end
      #1;
      PRESET = 1'b0;
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(32'd0);
         apb_read(regs[i], rd, rdy);
         e = exp_q.pop_front(); checks++;
         if (rd !== e) begin errors++; $display("FAIL reset_reg[%0d]: got %h expected %h", i, rd, e); end
      end
      idle(3);
      exp_q.push_back(32'd0);
      apb_read(A_CNT, rd, rdy);
      e = exp_q.pop_front(); checks++;
      if (rd !== e) begin errors++; $display("FAIL reset_cnt_hold: got %h expected %h", rd, e); end
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
   endtask

   task automatic test_autoreload();
      do_reset();
      start(0, 4, 5);
      for (int k = 1; k <= 15; k++) begin
         exp_q.push_back(32'(k % 5));
         irq_q.push_back(k >= 5);
      end
      PSEL = 1'b1; PWRITE = 1'b0; PADDR = A_CNT; PENABLE = 1'b0;
      @(posedge PCLK); #1;
      PENABLE = 1'b1;
      for (int j = 1; j <= 15; j++) begin
         #3;
         e = exp_q.pop_front(); checks++;
         if (PRDATA !== e) begin errors++; $display("FAIL autoreload_cnt k=%0d: got %h expected %h", j, PRDATA, e); end
         ei = irq_q.pop_front(); checks++;
         if (irq !== ei) begin errors++; $display("FAIL autoreload_irq k=%0d: got %b expected %b", j, irq, ei); end
         @(posedge PCLK); #1;
      end
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic test_prescale();
      int k;
      do_reset();
      start(2, 1, 1);
      for (int i = 0; i < 8; i++) begin
         k = cyc + 2 - cyc_en;
         exp_q.push_back(32'((k / 3) % 2));
         apb_read(A_CNT, rd, rdy);
         e = exp_q.pop_front(); checks++;
         if (rd !== e) begin errors++; $display("FAIL prescale_cnt k=%0d: got %h expected %h", k, rd, e); end
      end
      k = cyc + 2 - cyc_en;
      exp_q.push_back(32'(k >= 6));
      apb_read(A_SR, rd, rdy);
      e = exp_q.pop_front(); checks++;
      if (rd !== e) begin errors++; $display("FAIL prescale_uif k=%0d: got %h expected %h", k, rd, e); end
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL prescale_irq_masked: got %b expected 0", irq); end
   endtask

   task automatic test_collision();
      do_reset();
      start(0, 9, 5);
      wait_k(7);
      apb_write(A_SR, 32'd1);
      exp_q.push_back(32'd1);
      apb_read(A_SR, rd, rdy);
      e = exp_q.pop_front(); checks++;
      if (rd !== e) begin errors++; $display("FAIL collision_set_wins: got %h expected %h", rd, e); end
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL collision_irq: got %b expected 1", irq); end
      apb_write(A_SR, 32'd1);
      exp_q.push_back(32'd0);
      apb_read(A_SR, rd, rdy);
      e = exp_q.pop_front(); checks++;
      if (rd !== e) begin errors++; $display("FAIL collision_w1c: got %h expected %h", rd, e); end
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL collision_irq_clr: got %b expected 0", irq); end
   endtask

   task automatic test_arr_clr();
      do_reset();
      start(0, 100, 1);
      wait_k(7);
      apb_write(A_ARR, 32'd3);
      exp_q.push_back(32'd1);
      apb_read(A_CNT, rd, rdy);
      e = exp_q.pop_front(); checks++;
      if (rd !== e) begin errors++; $display("FAIL arr_lower_cnt: got %h expected %h", rd, e); end
      exp_q.push_back(32'd1);
      apb_read(A_SR, rd, rdy);
      e = exp_q.pop_front(); checks++;
      if (rd !== e) begin errors++; $display("FAIL arr_lower_uif: got %h expected %h", rd, e); end
      idle(1);
      apb_write(A_CR, 32'h6);
      exp_q.push_back(32'd0);
      apb_read(A_CNT, rd, rdy);
      e = exp_q.pop_front(); checks++;
      if (rd !== e) begin errors++; $display("FAIL clr_cnt: got %h expected %h", rd, e); end
      exp_q.push_back(32'h4);
      apb_read(A_CR, rd, rdy);
      e = exp_q.pop_front(); checks++;
      if (rd !== e) begin errors++; $display("FAIL clr_cr_dis: got %h expected %h", rd, e); end
      checks++;
      if (irq !== 1'b1) begin errors++; $display("FAIL clr_irq: got %b expected 1", irq); end
      apb_write(A_CR, 32'h7);
      exp_q.push_back(32'h5);
      apb_read(A_CR, rd, rdy);
      e = exp_q.pop_front(); checks++;
      if (rd !== e) begin errors++; $display("FAIL clr_cr_en: got %h expected %h", rd, e); end
   endtask

   task automatic test_unmapped();
      logic [31:0] ua [2];
      logic [31:0] ra [5];
      logic [31:0] rv [5];
      ua = '{32'h14, 32'h1C};
      ra = '{A_PSC, A_ARR, A_CNT, A_CR, A_SR};
      rv = '{32'd5, 32'd7, 32'd0, 32'd0, 32'd0};
      do_reset();
      apb_write(A_PSC, 32'd5);
      apb_write(A_ARR, 32'd7);
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back(32'd0);
         apb_read(ua[i], rd, rdy);
         e = exp_q.pop_front(); checks++;
         if (rd !== e) begin errors++; $display("FAIL unmapped_rd %h: got %h expected %h", ua[i], rd, e); end
         checks++;
         if (rdy !== 1'b1) begin errors++; $display("FAIL unmapped_pready %h: got %b expected 1", ua[i], rdy); end
         apb_write(ua[i], 32'hFFFF_FFFF);
      end
      apb_write(A_CNT, 32'h55);
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(rv[i]);
         apb_read(ra[i], rd, rdy);
         e = exp_q.pop_front(); checks++;
         if (rd !== e) begin errors++; $display("FAIL unmapped_keep %h: got %h expected %h", ra[i], rd, e); end
      end
   endtask

   initial begin
      do_reset();
      test_reset();
      test_autoreload();
      test_prescale();
      test_collision();
      test_arr_clr();
      test_unmapped();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
